// File: rtl/cpu_pkg.sv
// cpu_pkg: shared RV32M constants, multiply/divide FSM state encoding and
// divide special-case helpers used by muldiv_unit and div_iter_32.
package cpu_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned DIV_ITERS = 32;

   // M-extension funct3 codes
   localparam logic [2:0] MD_MUL    = 3'b000;
   localparam logic [2:0] MD_MULH   = 3'b001;
   localparam logic [2:0] MD_MULHSU = 3'b010;
   localparam logic [2:0] MD_MULHU  = 3'b011;
   localparam logic [2:0] MD_DIV    = 3'b100;
   localparam logic [2:0] MD_DIVU   = 3'b101;
   localparam logic [2:0] MD_REM    = 3'b110;
   localparam logic [2:0] MD_REMU   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_MUL  = 2'b01,
      S_DIV  = 2'b10,
      S_FIX  = 2'b11
   } md_state_t;

   // True for divide by zero or signed 0x80000000 / -1 (op must be a divide op)
   function automatic logic div_is_special(input logic [2:0]      op,
                                           input logic [XLEN-1:0] a,
                                           input logic [XLEN-1:0] b);
      return (b == '0) || (!op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1));
   endfunction

   // Architectural result for the special cases flagged by div_is_special
   function automatic logic [XLEN-1:0] div_special(input logic [2:0]      op,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
      logic [XLEN-1:0] r;
      if (b == '0) begin
         r = op[1] ? a : '1;
      end else begin
         r = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
      end
      return r;
   endfunction

endpackage

// File: rtl/div_iter_32.sv
// div_iter_32: one restoring shift-subtract divide step. Shifts the next
// dividend bit into the partial remainder, subtracts the divisor when it fits
// and reports the resulting quotient bit.
module div_iter_32
   import cpu_pkg::*;
(
   input  logic [XLEN-1:0] rem_in,
   input  logic            dvd_bit,
   input  logic [XLEN-1:0] dvs,
   output logic [XLEN-1:0] rem_out,
   output logic            q_bit
);

   logic [XLEN:0] shifted;

   // Trial subtraction; the partial remainder stays below the divisor so it
   // always fits back into XLEN bits.
   always_comb begin
      shifted = {rem_in, dvd_bit};
      q_bit   = (shifted >= {1'b0, dvs});
      rem_out = q_bit ? (shifted[XLEN-1:0] - dvs) : shifted[XLEN-1:0];
   end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
// START/BUSY/VALID handshake; multiply completes one edge after acceptance,
// divide runs 32 restoring steps plus one sign-fix edge.
// Optional build macro MULDIV_EARLY_OUT_EN: divide by zero, signed overflow
// and unsigned dividend < divisor complete one edge after acceptance.
module muldiv_unit
   import cpu_pkg::*;
#(
   parameter int unsigned XLEN = cpu_pkg::XLEN
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            START,
   input  logic            FLUSH,
   input  logic [2:0]      OPERATION,
   input  logic [XLEN-1:0] OPERAND1,
   input  logic [XLEN-1:0] OPERAND2,
   output logic [XLEN-1:0] RESULT,
   output logic            VALID,
   output logic            BUSY
);

   localparam logic [5:0] ITER_LAST = 6'(DIV_ITERS - 1);

   md_state_t       state_q, state_d;
   logic [2:0]      op_q, op_d;
   logic [XLEN-1:0] a_q, a_d, b_q, b_d;
   logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [5:0]      cnt_q, cnt_d;
   logic            qneg_q, qneg_d, rneg_q, rneg_d, spec_q, spec_d;
   logic            valid_q, valid_d;

   logic            acc_signed, acc_a_neg, acc_b_neg, acc_spec, acc_early;
   logic [XLEN-1:0] acc_a_mag, acc_b_mag;

   logic            mul_sgn_a, mul_sgn_b;
   logic [XLEN:0]   mul_a, mul_b;
   logic [2*XLEN-1:0] mul_p;
   logic [XLEN-1:0] mul_res, early_res, fix_res;

   logic [XLEN-1:0] step_rem;
   logic            step_q;

   div_iter_32 u_step (
      .rem_in  (rem_q),
      .dvd_bit (quo_q[XLEN-1]),
      .dvs     (dvs_q),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   // Operand preparation at acceptance: magnitudes, result signs, fast paths
   always_comb begin
      acc_signed = OPERATION[2] & ~OPERATION[0];
      acc_a_neg  = acc_signed & OPERAND1[XLEN-1];
      acc_b_neg  = acc_signed & OPERAND2[XLEN-1];
      acc_a_mag  = acc_a_neg ? -OPERAND1 : OPERAND1;
      acc_b_mag  = acc_b_neg ? -OPERAND2 : OPERAND2;
      acc_spec   = OPERATION[2] & div_is_special(OPERATION, OPERAND1, OPERAND2);
`ifdef MULDIV_EARLY_OUT_EN
      acc_early  = acc_spec |
                   (OPERATION[2] & OPERATION[0] & (OPERAND1 < OPERAND2));
`else
      acc_early  = 1'b0;
`endif
   end

   // 33x33 signed multiply on sign/zero-extended operands, plus the result
   // selection for the early-out and sign-fix completions
   always_comb begin
      mul_sgn_a = (op_q == MD_MULH) || (op_q == MD_MULHSU);
      mul_sgn_b = (op_q == MD_MULH);
      mul_a     = {mul_sgn_a & a_q[XLEN-1], a_q};
      mul_b     = {mul_sgn_b & b_q[XLEN-1], b_q};
      mul_p     = {{(XLEN-1){mul_a[XLEN]}}, mul_a} * {{(XLEN-1){mul_b[XLEN]}}, mul_b};
      mul_res   = (op_q == MD_MUL) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];

      if (spec_q) begin
         early_res = div_special(op_q, a_q, b_q);
      end else begin
         early_res = op_q[1] ? a_q : '0;
      end

      if (spec_q) begin
         fix_res = div_special(op_q, a_q, b_q);
      end else if (op_q[1]) begin
         fix_res = rneg_q ? -rem_q : rem_q;
      end else begin
         fix_res = qneg_q ? -quo_q : quo_q;
      end
   end

   // Next-state and datapath update; FLUSH overrides everything else
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      dvs_d    = dvs_q;
      cnt_d    = cnt_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      spec_d   = spec_q;
      result_d = result_q;
      valid_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (START) begin
               op_d    = OPERATION;
               a_d     = OPERAND1;
               b_d     = OPERAND2;
               quo_d   = acc_a_mag;
               dvs_d   = acc_b_mag;
               rem_d   = '0;
               cnt_d   = '0;
               qneg_d  = acc_a_neg ^ acc_b_neg;
               rneg_d  = acc_a_neg;
               spec_d  = acc_spec;
               state_d = (!OPERATION[2] || acc_early) ? S_MUL : S_DIV;
            end
         end
         S_MUL: begin
            result_d = op_q[2] ? early_res : mul_res;
            valid_d  = 1'b1;
            state_d  = S_IDLE;
         end
         S_DIV: begin
            rem_d = step_rem;
            quo_d = {quo_q[XLEN-2:0], step_q};
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == ITER_LAST) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            result_d = fix_res;
            valid_d  = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (FLUSH) begin
         state_d  = S_IDLE;
         valid_d  = 1'b0;
         result_d = result_q;
      end
   end

   // FSM state register
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand, divider and result registers
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
         dvs_q    <= '0;
         cnt_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         spec_q   <= 1'b0;
         result_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
         dvs_q    <= dvs_d;
         cnt_q    <= cnt_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         spec_q   <= spec_d;
         result_q <= result_d;
         valid_q  <= valid_d;
      end
   end

   assign RESULT = result_q;
   assign VALID  = valid_q;
   assign BUSY   = (state_q != S_IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with hand-computed results and latencies,
// plus a transaction-level model checked against the DUT every cycle.
`timescale 1ns/1ps
module tb_muldiv_unit;
   import cpu_pkg::*;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        START = 1'b0;
   logic        FLUSH = 1'b0;
   logic [2:0]  OPERATION = '0;
   logic [31:0] OPERAND1 = '0;
   logic [31:0] OPERAND2 = '0;
   logic [31:0] RESULT;
   logic        VALID;
   logic        BUSY;

   int n_assert = 0;
   int n_fail   = 0;
   int vcount   = 0;
   bit chk_en   = 1'b0;

`ifdef MULDIV_EARLY_OUT_EN
   localparam int EARLY_LAT = 1;
`else
   localparam int EARLY_LAT = 33;
`endif

   muldiv_unit #(.XLEN(32)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .START     (START),
      .FLUSH     (FLUSH),
      .OPERATION (OPERATION),
      .OPERAND1  (OPERAND1),
      .OPERAND2  (OPERAND2),
      .RESULT    (RESULT),
      .VALID     (VALID),
      .BUSY      (BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural RV32M result from plain 64-bit arithmetic
   function automatic logic [31:0] mdl_calc(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
      logic [63:0] p;
      int          q;
      logic [31:0] r;
      r = '0;
      case (op)
         3'd0: begin p = longint'($signed(a)) * longint'($signed(b)); r = p[31:0]; end
         3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); r = p[63:32]; end
         3'd2: begin p = longint'($signed(a)) * longint'(b);          r = p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b};                     r = p[63:32]; end
         3'd4, 3'd6: begin
            if (b == 32'd0) r = (op == 3'd4) ? 32'hFFFF_FFFF : a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = (op == 3'd4) ? 32'h8000_0000 : 32'd0;
            else begin
               q = (op == 3'd4) ? (int'(a) / int'(b)) : (int'(a) % int'(b));
               r = q;
            end
         end
         default: begin
            if (b == 32'd0) r = (op == 3'd5) ? 32'hFFFF_FFFF : a;
            else r = (op == 3'd5) ? (a / b) : (a % b);
         end
      endcase
      return r;
   endfunction

   // Edges from acceptance to VALID
   function automatic int mdl_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (!op[2]) return 1;
`ifdef MULDIV_EARLY_OUT_EN
      if (b == 32'd0) return 1;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      if (op[0] && a < b) return 1;
`endif
      return 33;
   endfunction

   // Transaction-level model: accept, count down the latency, deliver
   logic        m_busy = 1'b0, m_valid = 1'b0;
   logic [31:0] m_result = '0, m_pend = '0;
   int          m_left = 0;

   always @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         m_busy <= 1'b0; m_valid <= 1'b0; m_result <= '0; m_left <= 0;
      end else begin
         m_valid <= 1'b0;
         if (FLUSH) begin
            m_busy <= 1'b0; m_left <= 0;
         end else if (m_busy) begin
            if (m_left == 1) begin
               m_busy <= 1'b0; m_valid <= 1'b1; m_result <= m_pend;
            end
            m_left <= m_left - 1;
         end else if (START) begin
            m_busy <= 1'b1;
            m_left <= mdl_lat(OPERATION, OPERAND1, OPERAND2);
            m_pend <= mdl_calc(OPERATION, OPERAND1, OPERAND2);
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge CLK) begin
      if (VALID === 1'b1) vcount++;
      if (chk_en && RESET === 1'b1) begin
         check("cyc_busy",   {31'b0, BUSY},  {31'b0, m_busy});
         check("cyc_valid",  {31'b0, VALID}, {31'b0, m_valid});
         check("cyc_result", RESULT, m_result);
      end
   end

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat, input string name);
      int lat;
      bit seen;
      @(posedge CLK); #2;
      START = 1'b1; OPERATION = op; OPERAND1 = a; OPERAND2 = b;
      @(posedge CLK); #1;
      START = 1'b0;
      check({name, "_busy"}, {31'b0, BUSY}, 32'd1);
      seen = 1'b0; lat = 0;
      for (int k = 1; k <= 60 && !seen; k++) begin
         @(posedge CLK); #1;
         if (VALID) begin seen = 1'b1; lat = k; end
      end
      check({name, "_done"},   {31'b0, seen}, 32'd1);
      check({name, "_lat"},    lat, exp_lat);
      check({name, "_result"}, RESULT, exp);
      check({name, "_model"},  mdl_calc(op, a, b), exp);
      check({name, "_idle"},   {31'b0, BUSY}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int v0, vfirst, acc2, nv;
      bit prevb, seen;
      #2 RESET = 1'b0;
      #1;
      check("rst_result", RESULT, 32'd0);
      check("rst_busy",   {31'b0, BUSY},  32'd0);
      check("rst_valid",  {31'b0, VALID}, 32'd0);
      repeat (3) @(posedge CLK);
      #2 RESET = 1'b1;
      chk_en = 1'b1;

      run_op(MD_MULH,   32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1, "mulh");
      run_op(MD_MULHU,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1, "mulhu");
      run_op(MD_MUL,    32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 1, "mul");
      run_op(MD_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1, "mulhsu_neg");
      run_op(MD_MULHSU, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001, 1, "mulhsu_big");
      run_op(MD_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 1, "mul_shift");
      run_op(MD_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33, "div_m7_2");
      run_op(MD_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33, "rem_m7_2");
      run_op(MD_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div_7_m2");
      run_op(MD_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33, "rem_7_m2");
      run_op(MD_DIVU,   32'd100, 32'd7, 32'd14, 33, "divu");
      run_op(MD_REMU,   32'd100, 32'd7, 32'd2,  33, "remu");
      run_op(MD_DIVU,   32'd5, 32'd9, 32'd0, EARLY_LAT, "divu_lt");
      run_op(MD_REMU,   32'd5, 32'd9, 32'd5, EARLY_LAT, "remu_lt");
      run_op(MD_DIVU,   32'h0000_1234, 32'd0, 32'hFFFF_FFFF, EARLY_LAT, "divu_z");
      run_op(MD_REMU,   32'h0000_1234, 32'd0, 32'h0000_1234, EARLY_LAT, "remu_z");
      run_op(MD_DIV,    32'h8000_0000, 32'd0, 32'hFFFF_FFFF, EARLY_LAT, "div_z");
      run_op(MD_REM,    32'h8000_0000, 32'd0, 32'h8000_0000, EARLY_LAT, "rem_z");
      run_op(MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, EARLY_LAT, "div_ovf");
      run_op(MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, EARLY_LAT, "rem_ovf");
      run_op(MD_DIVU,   32'd100, 32'd7, 32'd14, 33, "divu_pre");

      // FLUSH on edge N+10 of a divide
      @(posedge CLK); #2;
      START = 1'b1; OPERATION = MD_DIV; OPERAND1 = 32'd1000; OPERAND2 = 32'd3;
      @(posedge CLK); #1;
      START = 1'b0;
      repeat (9) @(posedge CLK);
      #1 FLUSH = 1'b1;
      @(posedge CLK); #1;
      FLUSH = 1'b0;
      check("flush_busy",   {31'b0, BUSY},  32'd0);
      check("flush_valid",  {31'b0, VALID}, 32'd0);
      check("flush_result", RESULT, 32'd14);
      v0 = vcount;
      repeat (40) @(posedge CLK);
      check("flush_novalid", vcount - v0, 0);

      // Asynchronous reset in the middle of a divide
      @(posedge CLK); #2;
      START = 1'b1; OPERATION = MD_DIVU; OPERAND1 = 32'd1000; OPERAND2 = 32'd3;
      @(posedge CLK); #1;
      START = 1'b0;
      repeat (5) @(posedge CLK);
      #3 RESET = 1'b0;
      #1;
      check("amid_rst_result", RESULT, 32'd0);
      check("amid_rst_busy",   {31'b0, BUSY}, 32'd0);
      @(posedge CLK); #2 RESET = 1'b1;
      v0 = vcount;
      repeat (40) @(posedge CLK);
      check("rst_novalid", vcount - v0, 0);

      // START held high for 40 cycles across a divide
      @(posedge CLK); #2;
      START = 1'b1; OPERATION = MD_DIVU; OPERAND1 = 32'd100; OPERAND2 = 32'd7;
      vfirst = -1; acc2 = -1; nv = 0; prevb = BUSY;
      for (int i = 0; i < 40; i++) begin
         @(posedge CLK); #1;
         if (VALID) begin
            nv++;
            if (vfirst < 0) vfirst = i;
         end
         if (i > 0 && BUSY && !prevb && acc2 < 0) acc2 = i;
         prevb = BUSY;
      end
      START = 1'b0;
      check("hs_nvalid", nv, 1);
      check("hs_first_valid", vfirst, 33);
      check("hs_second_accept", acc2, 34);
      seen = 1'b0;
      for (int k = 0; k < 60 && !seen; k++) begin
         @(posedge CLK); #1;
         if (VALID) seen = 1'b1;
      end
      check("hs_second_done", {31'b0, seen}, 32'd1);
      check("hs_second_result", RESULT, 32'd14);

      repeat (3) @(posedge CLK);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
